// File: rtl/ysyx_23060240_ifu_pkg.sv
// Shared types and constants for the ysyx_23060240 instruction fetch unit.
package ysyx_23060240_ifu_pkg;

    typedef enum logic [2:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_NEXT
    } ifu_state_e;

    localparam logic [1:0]  FAULT_NONE       = 2'd0;
    localparam logic [1:0]  FAULT_MISALIGN   = 2'd1;
    localparam logic [1:0]  FAULT_BUS        = 2'd2;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060240_ifu_fetch.sv
// Multi-cycle fetch unit: one AXI4-Lite read per instruction, handed to decode
// over valid/ready, then parked until the next PC comes back.
module ysyx_23060240_ifu_fetch
    import ysyx_23060240_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [1:0]  out_fault,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    output logic [31:0] fetch_cnt
);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [1:0]  fault_q, fault_d;
    logic [31:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            fault_q <= FAULT_NONE;
            cnt_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_BOOT: state_d = S_REQ;
            S_REQ: begin
                if (arready) state_d = S_WAIT;
            end
            S_WAIT: begin
                // Error responses still forward rdata so decode sees what the bus returned.
                if (rvalid) begin
                    inst_d  = rdata;
                    fault_d = (rresp != 2'b00) ? FAULT_BUS : FAULT_NONE;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    cnt_d   = cnt_q + 32'd1;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (upd_valid) begin
                    pc_d = upd_pc;
                    if (upd_pc[1:0] == 2'b00) begin
                        state_d = S_REQ;
                    end else begin
                        // Misaligned target: report the fault without touching the bus.
                        inst_d  = NOP_INST;
                        fault_d = FAULT_MISALIGN;
                        state_d = S_OUT;
                    end
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    assign araddr    = pc_q;
    assign arvalid   = (state_q == S_REQ);
    assign rready    = (state_q == S_WAIT);
    assign out_valid = (state_q == S_OUT);
    assign out_inst  = inst_q;
    assign out_pc    = pc_q;
    assign out_fault = fault_q;
    assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_ysyx_23060240_ifu_fetch.sv
// Self-checking bench for the fetch unit: directed scenarios followed by a
// randomized instruction stream checked against a transaction-level model.
module tb_ysyx_23060240_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [1:0]  out_fault;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = 32'h0;
    logic [31:0] fetch_cnt;

    int tests = 0;
    int fails = 0;

    // Transaction-level model: the PC, the expected result, completed handshakes.
    logic [31:0] model_pc;
    logic [31:0] exp_inst;
    logic [1:0]  exp_fault;
    logic [31:0] model_cnt;
    bit          noise_en = 1'b0;

    ysyx_23060240_ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .out_fault(out_fault),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0297;
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; upd_valid noise is injected where the DUT must ignore it.
    task automatic step();
        if (noise_en) begin
            upd_valid = 1'($urandom_range(0, 1));
            upd_pc    = $urandom;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_arvalid"}, 32'(arvalid), 32'd0);
        chk({tag, "_rready"}, 32'(rready), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_araddr"}, araddr, 32'h8000_0000);
        chk({tag, "_out_pc"}, out_pc, 32'h8000_0000);
        chk({tag, "_out_inst"}, out_inst, 32'h0);
        chk({tag, "_out_fault"}, 32'(out_fault), 32'd0);
        chk({tag, "_fetch_cnt"}, fetch_cnt, 32'h0);
    endtask

    // Entered in REQ; leaves the DUT in WAIT.
    task automatic serve_ar(input int dly);
        chk("req_arvalid", 32'(arvalid), 32'd1);
        chk("req_araddr", araddr, model_pc);
        chk("req_rready", 32'(rready), 32'd0);
        for (int i = 0; i < dly; i++) begin
            arready = 1'b0;
            rvalid  = 1'($urandom_range(0, 1));
            rdata   = 32'hDEAD_BEEF;
            step();
            chk("req_hold_arvalid", 32'(arvalid), 32'd1);
            chk("req_hold_araddr", araddr, model_pc);
            chk("req_hold_rready", 32'(rready), 32'd0);
            chk("req_hold_out_valid", 32'(out_valid), 32'd0);
        end
        arready = 1'b1;
        rvalid  = 1'($urandom_range(0, 1));
        rdata   = 32'hDEAD_BEEF;
        step();
        arready = 1'b0;
        rvalid  = 1'b0;
        chk("wait_rready", 32'(rready), 32'd1);
        chk("wait_arvalid", 32'(arvalid), 32'd0);
        chk("wait_out_valid", 32'(out_valid), 32'd0);
    endtask

    // Entered in WAIT; leaves the DUT in OUT with the result checked.
    task automatic serve_r(input int dly, input logic [1:0] resp);
        for (int i = 0; i < dly; i++) begin
            rvalid = 1'b0;
            step();
            chk("wait_hold_rready", 32'(rready), 32'd1);
            chk("wait_hold_out_valid", 32'(out_valid), 32'd0);
        end
        rvalid = 1'b1;
        rdata  = mem_word(model_pc);
        rresp  = resp;
        step();
        rvalid = 1'b0;
        rresp  = 2'b00;
        exp_inst  = mem_word(model_pc);
        exp_fault = (resp != 2'b00) ? 2'd2 : 2'd0;
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("out_pc", out_pc, model_pc);
        chk("out_inst", out_inst, exp_inst);
        chk("out_fault", 32'(out_fault), 32'(exp_fault));
        chk("out_rready", 32'(rready), 32'd0);
    endtask

    // Entered in OUT; leaves the DUT in NEXT.
    task automatic serve_out(input int dly);
        for (int i = 0; i < dly; i++) begin
            out_ready = 1'b0;
            step();
            chk("out_hold_valid", 32'(out_valid), 32'd1);
            chk("out_hold_inst", out_inst, exp_inst);
            chk("out_hold_pc", out_pc, model_pc);
            chk("out_hold_fault", 32'(out_fault), 32'(exp_fault));
            chk("out_hold_cnt", fetch_cnt, model_cnt);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        model_cnt = model_cnt + 32'd1;
        chk("next_out_valid", 32'(out_valid), 32'd0);
        chk("next_arvalid", 32'(arvalid), 32'd0);
        chk("next_cnt", fetch_cnt, model_cnt);
    endtask

    // Entered in NEXT; returns 1 when the new PC is misaligned (DUT in OUT).
    task automatic serve_upd(input logic [31:0] npc, input int dly, output bit mis);
        noise_en  = 1'b0;
        upd_valid = 1'b0;
        for (int i = 0; i < dly; i++) begin
            step();
            chk("next_hold_arvalid", 32'(arvalid), 32'd0);
            chk("next_hold_out_valid", 32'(out_valid), 32'd0);
        end
        upd_valid = 1'b1;
        upd_pc    = npc;
        step();
        upd_valid = 1'b0;
        noise_en  = 1'b1;
        model_pc  = npc;
        mis       = (npc[1:0] != 2'b00);
        if (mis) begin
            exp_inst  = 32'h0000_0013;
            exp_fault = 2'd1;
            chk("mis_arvalid", 32'(arvalid), 32'd0);
            chk("mis_out_valid", 32'(out_valid), 32'd1);
            chk("mis_out_pc", out_pc, npc);
            chk("mis_out_inst", out_inst, exp_inst);
            chk("mis_out_fault", 32'(out_fault), 32'(exp_fault));
        end else begin
            chk("upd_arvalid", 32'(arvalid), 32'd1);
            chk("upd_out_valid", 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        bit          mis;
        logic [31:0] npc;
        int          pick;

        model_pc  = 32'h8000_0000;
        model_cnt = 32'h0;
        exp_inst  = 32'h0;
        exp_fault = 2'd0;

        // Reset held across a few edges, then released mid-cycle.
        repeat (3) step();
        check_reset_values("rst");
        rst = 1'b1;
        chk("boot_arvalid", 32'(arvalid), 32'd0);
        noise_en = 1'b1;
        step();

        // Zero-wait fetch of the reset PC.
        serve_ar(0);
        serve_r(0, 2'b00);
        serve_out(0);
        serve_upd(32'h8000_0004, 0, mis);

        // Stalled AR, delayed R, stalled decode.
        serve_ar(3);
        serve_r(4, 2'b00);
        serve_out(5);

        // Misaligned redirect, then a bus-error fetch.
        serve_upd(32'h8000_0006, 0, mis);
        serve_out(2);
        serve_upd(32'h8000_0010, 1, mis);
        serve_ar(0);
        serve_r(1, 2'b10);
        serve_out(0);
        serve_upd(32'h8000_0014, 0, mis);

        // Asynchronous reset while waiting on read data.
        serve_ar(1);
        rvalid = 1'b0;
        step();
        rst    = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'hBAD0_BAD0;
        #1;
        check_reset_values("arst");
        step();
        rvalid = 1'b0;
        rst    = 1'b1;
        model_pc  = 32'h8000_0000;
        model_cnt = 32'h0;
        chk("arst_boot_arvalid", 32'(arvalid), 32'd0);
        step();
        serve_ar(2);
        serve_r(0, 2'b00);
        serve_out(1);

        // Randomized instruction stream.
        for (int n = 0; n < 40; n++) begin
            pick = $urandom_range(0, 7);
            if (pick < 4)       npc = model_pc + 32'd4;
            else if (pick < 6)  npc = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
            else                npc = (model_pc & 32'hFFFF_FFFC) + 32'($urandom_range(1, 3));
            serve_upd(npc, $urandom_range(0, 3), mis);
            if (!mis) begin
                serve_ar($urandom_range(0, 3));
                serve_r($urandom_range(0, 3),
                        ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
            end
            serve_out($urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ysyx_23060240_ifu_fetch.md
# ysyx_23060240_ifu_fetch

Multi-cycle instruction fetch unit that sits directly upstream of the decode stage (IDU). It holds the architectural PC and issues one AXI4-Lite read per instruction. It presents the fetched instruction with its PC and a fault code to decode over a valid/ready handshake. It then waits for the downstream stage to return the next PC before fetching again.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC loaded at reset; first fetch address.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- araddr  out  32  AXI read address; equals the current PC.
- arvalid  out  1  AXI read-address valid.
- arready  in  1  AXI read-address ready.
- rdata  in  32  AXI read data.
- rresp  in  2  AXI read response; nonzero means bus error.
- rvalid  in  1  AXI read-data valid.
- rready  out  1  AXI read-data ready.
- out_valid  out  1  instruction available to IDU.
- out_ready  in  1  IDU accepts instruction.
- out_inst  out  32  fetched instruction word.
- out_pc  out  32  PC of out_inst.
- out_fault  out  2  fault code: 0 none, 1 misaligned PC, 2 bus error.
- upd_valid  in  1  next-PC valid, from the execute/writeback side.
- upd_pc  in  32  next PC: pc+4, branch/jump target, or CSR vector.
- fetch_cnt  out  32  count of completed out handshakes; wraps modulo 2^32.

## Operation
- States: BOOT, REQ, WAIT, OUT, NEXT. Reset state is BOOT.
- BOOT -> REQ unconditionally on the first clock edge after rst deasserts.
- REQ:
  - arvalid=1 and araddr=pc.
  - arvalid and araddr stay stable until arready.
  - On arvalid&&arready -> WAIT.
- WAIT:
  - rready=1.
  - On rvalid: capture inst_q<=rdata.
  - fault_q<=2 if rresp!=0, else 0.
  - -> OUT.
- OUT:
  - out_valid=1. out_inst, out_pc and out_fault are held stable until out_ready.
  - On out_ready: fetch_cnt+=1 -> NEXT.
- NEXT:
  - Wait for upd_valid. On upd_valid: pc<=upd_pc.
  - If upd_pc[1:0]==0 -> REQ.
  - Otherwise -> OUT with fault_q=1 and inst_q=32'h0000_0013 (NOP). No bus request is issued.
- upd_valid is ignored in every state except NEXT.
- rvalid is ignored outside WAIT. rready=0 prevents acceptance.
- When out_fault=2, out_inst holds the rdata returned with the error response.
- The bus request cannot be abandoned. There is no flush; redirection happens only through upd_pc.

## Timing
- Reset values:
  - arvalid=0, rready=0, out_valid=0.
  - araddr=RESET_PC, out_pc=RESET_PC.
  - out_inst=0, out_fault=0, fetch_cnt=0.
- All outputs are registered or decoded from the state register only. There is no combinational path from an input to an output.
- Minimum latency, with arready and rvalid high whenever sampled:
  - REQ 1 cycle, WAIT 1 cycle.
  - out_valid is asserted 2 cycles after entering REQ.
- Minimum loop, assuming same-cycle out_ready and upd_valid: REQ, WAIT, OUT, NEXT = 4 cycles per instruction.
- Upd to the next arvalid: 1 cycle.
- Misaligned upd_pc to out_valid: 1 cycle.
- rvalid asserted in the same cycle as the AR handshake is not accepted. Acceptance is earliest the next cycle.
- Asserting rst mid-transaction returns the block to BOOT immediately. Any outstanding AXI response is dropped; the interconnect must be reset together with this block.
- fetch_cnt wraps from 32'hFFFF_FFFF to 0.

## Structure
- Package ysyx_23060240_ifu_pkg holds:
  - the state enum (BOOT/REQ/WAIT/OUT/NEXT);
  - fault-code constants FAULT_NONE, FAULT_MISALIGN, FAULT_BUS;
  - the NOP constant 32'h0000_0013;
  - the default reset PC.
- Single module; no sub-module is required. The AXI handshake is small enough to live in the FSM.

## Test plan
- Reset, then zero-wait memory returning 32'h0000_0297 at 32'h8000_0000:
  - arvalid rises 1 cycle after release with araddr=32'h8000_0000;
  - out_valid 2 cycles later with out_inst=32'h0000_0297 and out_fault=0.
- arready held low 3 cycles, then rvalid delayed 4 cycles:
  - araddr and arvalid stay stable throughout;
  - out_valid appears only after rvalid;
  - rready is 0 before the AR handshake.
- out_ready held low 5 cycles:
  - out_valid, out_inst and out_pc stay stable;
  - fetch_cnt stays unchanged until the handshake, then increments by 1.
- upd_pc=32'h8000_0006:
  - no arvalid;
  - out_valid the next cycle with out_pc=32'h8000_0006, out_inst=32'h0000_0013, out_fault=1.
- rresp=2'b10 on a fetch of 32'h8000_0010: out_fault=2, out_pc=32'h8000_0010.
- rst asserted during WAIT:
  - outputs return to reset values asynchronously;
  - after release, fetch restarts at 32'h8000_0000;
  - upd_valid pulses in REQ, WAIT and OUT have no effect.
